multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multi-cycle control FSM for the RV32 core. Sequences fetch, decode, execute, memory and
//   writeback around the instruction decoder, ALU, register file and PC.
//   Consumes the decoder's opcode/funct3 fields and the branch comparator result.
//   Drives the memory handshakes and every datapath enable/select.
//   Unsupported opcodes and data-bus timeouts end in a sticky TRAP state.
// PARAMETERS
//   MEM_TIMEOUT  15  max cycles in MEM without dmem_ack before trapping (1..255)
// PORTS
//   clk        in   1  single clock; all state updates on rising edge
//   rst        in   1  synchronous, active-high reset
//   opcode     in   7  decoder opcode field (valid from DECODE onward; IR stable)
//   funct3     in   3  decoder funct3 field
//   br_cond    in   1  branch comparator result (comparator already applies funct3)
//   imem_req   out  1  instruction fetch request
//   imem_ack   in   1  instruction word valid this cycle
//   ir_we      out  1  load instruction register
//   dmem_req   out  1  data access request
//   dmem_we    out  1  1=store, 0=load (valid while dmem_req)
//   dmem_ack   in   1  data access complete this cycle
//   alu_src_b  out  1  0=rs2, 1=imm_out
//   alu_op     out  2  00=add, 01=sub/compare, 10=funct3/funct7-decoded
//   pc_we      out  1  update PC this cycle
//   pc_src     out  1  0=pc+4, 1=pc+imm
//   rf_we      out  1  register-file write enable (x0 filtered by the regfile)
//   wb_sel     out  2  00=ALU, 01=load data, 10=pc+4
//   instret    out  1  one-cycle pulse on instruction retire
//   trap       out  1  sticky illegal-instruction / bus-timeout flag
//   state_o    out  3  current state, for debug
// BEHAVIOUR
// - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
// - Outputs are combinational from state, the latched class, and ack/br_cond.
// - Any output not listed for the current state is 0.
// - rst high: next state is FETCH, the timeout counter clears, and trap clears.
//   All outputs read 0 while rst is high.
// - FETCH: imem_req=1 until imem_ack. On ack: ir_we=1 and next state is DECODE.
//   imem_ack in any other state is ignored.
// - DECODE: one cycle. Classify opcode and register the class:
//   - R: 0110011
//   - I: 0010011
//   - LD: 0000011
//   - ST: 0100011
//   - BR: 1100011
//   - JAL: 1101111
//   Any other opcode goes to TRAP.
// - EXEC, by class:
//   - R: alu_src_b=0, alu_op=10; next WB.
//   - I: alu_src_b=1, alu_op=10; next WB.
//   - LD/ST: alu_src_b=1, alu_op=00; next MEM.
//   - BR: alu_src_b=0, alu_op=01, pc_we=1, pc_src=br_cond, instret=1; next FETCH.
//   - JAL: next WB.
// - MEM: dmem_req=1, dmem_we=(class==ST), held until dmem_ack. The counter increments each
//   no-ack cycle. On ack:
//   - LD: next WB.
//   - ST: pc_we=1, pc_src=0, instret=1; next FETCH.
// - MEM timeout: counter==MEM_TIMEOUT-1 with no ack goes to TRAP.
//   An ack in that same cycle wins. The counter clears on MEM entry.
// - WB: rf_we=1 for one cycle, then next FETCH.
//   - R/I: wb_sel=00.
//   - LD: wb_sel=01.
//   - JAL: wb_sel=10, pc_src=1.
//   All classes also assert pc_we=1 and instret=1; pc_src=0 except JAL.
// - TRAP: trap=1. All enables and requests are 0. Only rst exits TRAP.
// - Latency with zero-wait acks:
//   - BR: 3 cycles
//   - R/I/JAL/ST: 4 cycles
//   - LD: 5 cycles
// - Every wait-state adds exactly one cycle.
// - rst mid-access: requests drop on the next cycle. No pc_we, rf_we or instret is issued for
//   the aborted instruction.
// TESTING
// - ADDI (0x00500093), imem_ack on first request cycle:
//   -> states 0,1,2,4; rf_we=1, wb_sel=00 in cycle 4; instret exactly once.
// - LW with dmem_ack delayed 3 cycles:
//   -> dmem_req=1 and dmem_we=0 for 4 cycles; WB with wb_sel=01; total 8 cycles.
// - BEQ with br_cond=1, then br_cond=0:
//   -> pc_we=1 in EXEC with pc_src=1, then pc_src=0; rf_we never asserted.
// - Opcode 0x7F, then SW with dmem_ack never asserted (MEM_TIMEOUT=15):
//   -> trap=1 after DECODE; SW traps after 15 MEM cycles.
//   -> dmem_ack on the 15th cycle completes the store instead.
// - rst pulsed during MEM, and again while in TRAP:
//   -> FETCH next cycle; dmem_req drops; no instret; trap cleared.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and select. Illegal opcodes and data-bus timeouts trap.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_cond,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_we,
  output logic       pc_src,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       instret,
  output logic       trap,
  output logic [2:0] state_o
);

  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_BR  = 3'd4,
    C_JAL = 3'd5
  } cls_t;

  state_t         state;
  cls_t           cls;
  cls_t           dec_cls;
  logic           dec_ok;
  logic [CW-1:0]  cnt;

  // The branch comparator already folds in funct3, so the sequencer never needs it.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  // Opcode classification used in DECODE
  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_R;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_ST;
      7'b1100011: dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // State, latched class and MEM wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cls   <= C_R;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH:  if (imem_ack) state <= S_DECODE;
        S_DECODE: begin
          if (dec_ok) begin
            cls   <= dec_cls;
            state <= S_EXEC;
          end else begin
            state <= S_TRAP;
          end
        end
        S_EXEC: begin
          cnt <= '0;
          case (cls)
            C_LD, C_ST: state <= S_MEM;
            C_BR:       state <= S_FETCH;
            default:    state <= S_WB;
          endcase
        end
        S_MEM: begin
          // An ack on the final allowed cycle still completes the access.
          if (dmem_ack)                             state <= (cls == C_LD) ? S_WB : S_FETCH;
          else if (cnt == CW'(MEM_TIMEOUT - 1))     state <= S_TRAP;
          else                                      cnt   <= cnt + CW'(1);
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Outputs decoded from state, class and the handshake inputs; forced low during reset
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    instret   = 1'b0;
    trap      = 1'b0;
    state_o   = 3'd0;
    if (!rst) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          case (cls)
            C_R:  alu_op = 2'b10;
            C_I: begin
              alu_src_b = 1'b1;
              alu_op    = 2'b10;
            end
            C_LD, C_ST: alu_src_b = 1'b1;
            C_BR: begin
              alu_op  = 2'b01;
              pc_we   = 1'b1;
              pc_src  = br_cond;
              instret = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == C_ST);
          if (dmem_ack && cls == C_ST) begin
            pc_we   = 1'b1;
            instret = 1'b1;
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          instret = 1'b1;
          case (cls)
            C_LD:    wb_sel = 2'b01;
            C_JAL: begin
              wb_sel = 2'b10;
              pc_src = 1'b1;
            end
            default: wb_sel = 2'b00;
          endcase
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues its hand-computed
// output vector, and a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_cond;
  logic       imem_req, imem_ack, ir_we;
  logic       dmem_req, dmem_we, dmem_ack;
  logic       alu_src_b, pc_we, pc_src, rf_we, instret, trap;
  logic [1:0] alu_op, wb_sel;
  logic [2:0] state_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      nm;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_cond(br_cond),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_we(pc_we), .pc_src(pc_src),
    .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Vector layout: state, imem_req, ir_we, dmem_req, dmem_we, alu_src_b, alu_op,
  // pc_we, pc_src, rf_we, wb_sel, instret, trap
  function automatic logic [16:0] v(input logic [2:0] st, input logic ireq, irwe, dreq, dwe,
                                    asb, input logic [1:0] aop, input logic pcwe, pcs, rfwe,
                                    input logic [1:0] ws, input logic ret, trp);
    return {st, ireq, irwe, dreq, dwe, asb, aop, pcwe, pcs, rfwe, ws, ret, trp};
  endfunction

  function automatic logic [16:0] actual();
    return {state_o, imem_req, ir_we, dmem_req, dmem_we, alu_src_b, alu_op,
            pc_we, pc_src, rf_we, wb_sel, instret, trap};
  endfunction

  // One clock of stimulus, called just after a rising edge
  task automatic cyc(input string nm, input logic r, ia, da, bc, input logic [6:0] op,
                     input logic [16:0] e);
    exp_t x;
    rst      = r;
    imem_ack = ia;
    dmem_ack = da;
    br_cond  = bc;
    opcode   = op;
    x.nm = nm;
    x.v  = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      compared++;
      if (actual() !== x.v) begin
        mismatched++;
        $display("FAIL %s: got %b required %b", x.nm, actual(), x.v);
      end
    end
  end

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_BAD = 7'h7F;

  initial begin
    logic [16:0] zero, f_wait, f_ack, dec, ex_mem, trp;
    zero   = v(3'd0, 0,0,0,0,0,2'd0,0,0,0,2'd0,0,0);
    f_wait = v(3'd0, 1,0,0,0,0,2'd0,0,0,0,2'd0,0,0);
    f_ack  = v(3'd0, 1,1,0,0,0,2'd0,0,0,0,2'd0,0,0);
    dec    = v(3'd1, 0,0,0,0,0,2'd0,0,0,0,2'd0,0,0);
    ex_mem = v(3'd2, 0,0,0,0,1,2'd0,0,0,0,2'd0,0,0);
    trp    = v(3'd7, 0,0,0,0,0,2'd0,0,0,0,2'd0,0,1);
    funct3 = 3'd0;
    rst = 1'b1; imem_ack = 0; dmem_ack = 0; br_cond = 0; opcode = OP_I;
    @(posedge clk); #1;

    cyc("reset_zero", 1, 1, 1, 1, OP_I, zero);

    // ADDI, zero-wait fetch
    cyc("addi_fetch", 0, 1, 0, 0, OP_I, f_ack);
    cyc("addi_dec",   0, 0, 0, 0, OP_I, dec);
    cyc("addi_exec",  0, 0, 0, 0, OP_I, v(3'd2, 0,0,0,0,1,2'd2,0,0,0,2'd0,0,0));
    cyc("addi_wb",    0, 0, 0, 0, OP_I, v(3'd4, 0,0,0,0,0,2'd0,1,0,1,2'd0,1,0));

    // LW: one fetch wait, dmem_ack delayed 3 cycles
    cyc("lw_fwait",  0, 0, 0, 0, OP_LD, f_wait);
    cyc("lw_fetch",  0, 1, 0, 0, OP_LD, f_ack);
    cyc("lw_dec",    0, 0, 0, 0, OP_LD, dec);
    cyc("lw_exec",   0, 0, 0, 0, OP_LD, ex_mem);
    for (int i = 0; i < 3; i++)
      cyc("lw_mwait", 0, 0, 0, 0, OP_LD, v(3'd3, 0,0,1,0,0,2'd0,0,0,0,2'd0,0,0));
    cyc("lw_mack",   0, 0, 1, 0, OP_LD, v(3'd3, 0,0,1,0,0,2'd0,0,0,0,2'd0,0,0));
    cyc("lw_wb",     0, 0, 0, 0, OP_LD, v(3'd4, 0,0,0,0,0,2'd0,1,0,1,2'd1,1,0));

    // BEQ taken then not taken
    cyc("beq1_fetch", 0, 1, 0, 0, OP_BR, f_ack);
    cyc("beq1_dec",   0, 0, 0, 0, OP_BR, dec);
    cyc("beq1_exec",  0, 0, 0, 1, OP_BR, v(3'd2, 0,0,0,0,0,2'd1,1,1,0,2'd0,1,0));
    cyc("beq0_fetch", 0, 1, 0, 0, OP_BR, f_ack);
    cyc("beq0_dec",   0, 0, 0, 1, OP_BR, dec);
    cyc("beq0_exec",  0, 0, 0, 0, OP_BR, v(3'd2, 0,0,0,0,0,2'd1,1,0,0,2'd0,1,0));

    // R-type
    cyc("r_fetch", 0, 1, 0, 0, OP_R, f_ack);
    cyc("r_dec",   0, 0, 0, 0, OP_R, dec);
    cyc("r_exec",  0, 0, 0, 0, OP_R, v(3'd2, 0,0,0,0,0,2'd2,0,0,0,2'd0,0,0));
    cyc("r_wb",    0, 0, 0, 0, OP_R, v(3'd4, 0,0,0,0,0,2'd0,1,0,1,2'd0,1,0));

    // JAL
    cyc("jal_fetch", 0, 1, 0, 0, OP_JAL, f_ack);
    cyc("jal_dec",   0, 0, 0, 0, OP_JAL, dec);
    cyc("jal_exec",  0, 0, 0, 0, OP_JAL, v(3'd2, 0,0,0,0,0,2'd0,0,0,0,2'd0,0,0));
    cyc("jal_wb",    0, 0, 0, 0, OP_JAL, v(3'd4, 0,0,0,0,0,2'd0,1,1,1,2'd2,1,0));

    // SW zero-wait
    cyc("sw_fetch", 0, 1, 0, 0, OP_ST, f_ack);
    cyc("sw_dec",   0, 0, 0, 0, OP_ST, dec);
    cyc("sw_exec",  0, 0, 0, 0, OP_ST, ex_mem);
    cyc("sw_mack",  0, 0, 1, 0, OP_ST, v(3'd3, 0,0,1,1,0,2'd0,1,0,0,2'd0,1,0));

    // Illegal opcode traps; imem_ack ignored in TRAP; rst clears
    cyc("bad_fetch", 0, 1, 0, 0, OP_BAD, f_ack);
    cyc("bad_dec",   0, 0, 0, 0, OP_BAD, dec);
    cyc("bad_trap",  0, 0, 0, 0, OP_BAD, trp);
    cyc("bad_hold",  0, 1, 1, 0, OP_I,   trp);
    cyc("trap_rst",  1, 0, 0, 0, OP_I,   zero);
    cyc("post_rst",  0, 0, 0, 0, OP_I,   f_wait);

    // SW timeout: 15 MEM cycles without ack, then TRAP
    cyc("swto_fetch", 0, 1, 0, 0, OP_ST, f_ack);
    cyc("swto_dec",   0, 0, 0, 0, OP_ST, dec);
    cyc("swto_exec",  0, 0, 0, 0, OP_ST, ex_mem);
    for (int i = 0; i < 15; i++)
      cyc("swto_mem", 0, 0, 0, 0, OP_ST, v(3'd3, 0,0,1,1,0,2'd0,0,0,0,2'd0,0,0));
    cyc("swto_trap",  0, 0, 0, 0, OP_ST, trp);
    cyc("swto_rst",   1, 0, 0, 0, OP_ST, zero);

    // SW with ack on the 15th MEM cycle completes
    cyc("sw15_fetch", 0, 1, 0, 0, OP_ST, f_ack);
    cyc("sw15_dec",   0, 0, 0, 0, OP_ST, dec);
    cyc("sw15_exec",  0, 0, 0, 0, OP_ST, ex_mem);
    for (int i = 0; i < 14; i++)
      cyc("sw15_mem", 0, 0, 0, 0, OP_ST, v(3'd3, 0,0,1,1,0,2'd0,0,0,0,2'd0,0,0));
    cyc("sw15_ack",   0, 0, 1, 0, OP_ST, v(3'd3, 0,0,1,1,0,2'd0,1,0,0,2'd0,1,0));
    cyc("sw15_next",  0, 0, 0, 0, OP_ST, f_wait);

    // rst during MEM of a load: no retire, back to FETCH
    cyc("rlw_fetch", 0, 1, 0, 0, OP_LD, f_ack);
    cyc("rlw_dec",   0, 0, 0, 0, OP_LD, dec);
    cyc("rlw_exec",  0, 0, 0, 0, OP_LD, ex_mem);
    cyc("rlw_mem",   0, 0, 0, 0, OP_LD, v(3'd3, 0,0,1,0,0,2'd0,0,0,0,2'd0,0,0));
    cyc("rlw_rst",   1, 0, 1, 0, OP_LD, zero);
    cyc("rlw_after", 0, 0, 1, 0, OP_LD, f_wait);

    @(posedge clk); #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
